uart_tx_port: RTL

Memory-mapped serial transmitter that responds on the CPU's memory bus (address, shared 16-bit data bus, active-low OE/WE/CS), alongside the SRAM. The CPU writes bytes into a small FIFO through a DATA register. An 8N1 shifter drains the FIFO onto a serial line. A STATUS register lets the microcode-driven CPU poll fill level, busy state and overflow.

---
 rtl/uart_tx_port.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 serial transmitter: DATA/STATUS registers on the CPU bus,
// a small circular byte FIFO and a shifter with a registered txd output.
module uart_tx_port #(
    parameter logic [15:0] BASE_ADDR    = 16'hFF00,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    inout  wire  [15:0] dataBus,
    input  logic        notOE,
    input  logic        notWE,
    input  logic        notCS,
    output logic        txd,
    output logic        busy
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST   = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_CNT   = CW'(FIFO_DEPTH);
    localparam logic [15:0]   STATUS_ADDR = BASE_ADDR + 16'd1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // Bus decode
    logic sel_data, sel_stat, rd_en, wr_data, wr_stat;
    logic wr_data_q, wr_stat_q;
    logic push_req, stat_wr, flush, ovf_clr;
    logic [7:0]  wr_byte;
    logic [15:0] status_word, rd_data;
    logic [3:0]  count_nib;
    logic        unused_bus_hi;

    // FIFO
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          ovf_q, full, empty, push_ok, pop;

    // Shifter
    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          baud_last;

    assign sel_data = !notCS && (address == BASE_ADDR);
    assign sel_stat = !notCS && (address == STATUS_ADDR);
    assign wr_data  = sel_data && !notWE;
    assign wr_stat  = sel_stat && !notWE;
    assign rd_en    = (sel_data || sel_stat) && !notOE && notWE;

    // Only the first cycle of a held-low write strobe acts.
    assign push_req = wr_data && !wr_data_q;
    assign stat_wr  = wr_stat && !wr_stat_q;
    assign flush    = stat_wr && dataBus[0];
    assign ovf_clr  = stat_wr && dataBus[3];
    assign wr_byte  = dataBus[7:0];
    assign unused_bus_hi = ^dataBus[15:8];

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign push_ok = push_req && (!full || pop);
    assign busy    = (state_q != S_IDLE) || !empty;

    assign count_nib   = 4'(count_q);
    assign status_word = {8'h00, count_nib, ovf_q, busy, empty, full};
    assign rd_data     = sel_stat ? status_word : 16'h0000;
    assign dataBus     = rd_en ? rd_data : 16'hzzzz;

    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= wr_byte;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            wr_data_q <= 1'b0;
            wr_stat_q <= 1'b0;
        end else begin
            wr_data_q <= wr_data;
            wr_stat_q <= wr_stat;
            // Flush leaves the shifter alone; a same-edge pop simply lands on an empty FIFO.
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
                if (push_ok && !pop)      count_q <= count_q + 1'b1;
                else if (!push_ok && pop) count_q <= count_q - 1'b1;
            end
            if (ovf_clr) begin
                ovf_q <= 1'b0;
            end else if (push_req && full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_mem[rd_ptr_q];
                    state_d = S_START;
                    baud_d  = '0;
                    txd_d   = 1'b0;
                end
            end
            S_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                    txd_d   = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        txd_d   = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more data is waiting.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_mem[rd_ptr_q];
                        state_d = S_START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    assign txd = txd_q;

endmodule
